sram_scheduler: RTL and testbench

Per-cycle access scheduler for the foreground SRAM port. It shares one `sram_interface` command slot between three requesters: pipeline foreground reads, ADC live-video writes and SPI still-image writes. It sequences freeze/thaw on frame boundaries and returns read data at a fixed latency. It sits between the ADC FIFO, the SPI image loader, the foreground pipeline and `sram_interface`.

---
 rtl/sram_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_sram_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_scheduler.sv
// ---------------------------------------------------------------------------
// sram_scheduler
//
// Per-cycle owner of the single foreground SRAM command slot. Three
// requesters compete for it: pipeline reads, ADC live-video writes and SPI
// still-image writes. A four-state freeze FSM decides which writer owns the
// frame. State changes only on frame boundaries, which are ADC words at
// (0,0). Read data comes back at a fixed latency, and so do blank results
// for out-of-bounds reads.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   freeze_req                      1 = want frozen image, 0 = live video
//   frozen                          1 in FROZEN / THAW_ARMED
//   request_active/_x/_y            pipeline read request (signed coords)
//   request_data/_ready             read result, RD_LAT+2 cycles after issue
//   adc_pixel_data/_ready           show-ahead FIFO word {x, y, rgb565}
//   adc_pixel_read                  combinational FIFO pop
//   spi_pixel_ready/_in/_x/_y       held SPI pixel (signed coords)
//   spi_pixel_read                  one-cycle acknowledge
//   cmd_valid/_we/_addr/_wdata      registered command to sram_interface
//   sram_rdata                      read data from sram_interface
//   adc_drop_count                  saturating out-of-bounds ADC word count
// ---------------------------------------------------------------------------
module sram_scheduler #(
    parameter int X_RES     = 800,
    parameter int Y_RES     = 600,
    parameter int PRECISION = 11,
    parameter int RD_LAT    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 freeze_req,
    output logic                 frozen,
    input  logic                 request_active,
    input  logic [PRECISION:0]   request_x,
    input  logic [PRECISION:0]   request_y,
    output logic [15:0]          request_data,
    output logic                 request_ready,
    input  logic [37:0]          adc_pixel_data,
    input  logic                 adc_pixel_ready,
    output logic                 adc_pixel_read,
    input  logic                 spi_pixel_ready,
    input  logic [15:0]          spi_pixel_in,
    input  logic [PRECISION:0]   spi_pixel_x,
    input  logic [PRECISION:0]   spi_pixel_y,
    output logic                 spi_pixel_read,
    output logic                 cmd_valid,
    output logic                 cmd_we,
    output logic [19:0]          cmd_addr,
    output logic [16:0]          cmd_wdata,
    input  logic [16:0]          sram_rdata,
    output logic [15:0]          adc_drop_count
);

    localparam int AW = 20;

    typedef enum logic [1:0] {
        LIVE         = 2'd0,
        FREEZE_ARMED = 2'd1,
        FROZEN       = 2'd2,
        THAW_ARMED   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Linear address from the low PRECISION bits of each coordinate.
    function automatic logic [AW-1:0] pix_addr(input logic [PRECISION-1:0] x,
                                               input logic [PRECISION-1:0] y);
        return AW'(y) * AW'(X_RES) + AW'(x);
    endfunction

    // ---------------- request decode ----------------
    logic signed [PRECISION:0] req_x_s, req_y_s, spi_x_s, spi_y_s;
    logic                      req_in, spi_in;

    assign req_x_s = request_x;
    assign req_y_s = request_y;
    assign spi_x_s = spi_pixel_x;
    assign spi_y_s = spi_pixel_y;

    assign req_in = (int'(req_x_s) >= 0) && (int'(req_x_s) < X_RES) &&
                    (int'(req_y_s) >= 0) && (int'(req_y_s) < Y_RES);
    assign spi_in = (int'(spi_x_s) >= 0) && (int'(spi_x_s) < X_RES) &&
                    (int'(spi_y_s) >= 0) && (int'(spi_y_s) < Y_RES);

    // ---------------- ADC word decode ----------------
    logic [10:0] adc_x, adc_y;
    logic [15:0] adc_rgb;
    logic        adc_pop, adc_in, frame_start;

    assign adc_x   = adc_pixel_data[37:27];
    assign adc_y   = adc_pixel_data[26:16];
    assign adc_rgb = adc_pixel_data[15:0];

    // A read owns the slot outright; otherwise any ready ADC word is popped
    // whether or not it ends up written.
    assign adc_pop        = adc_pixel_ready & ~request_active;
    assign adc_pixel_read = adc_pop;

    assign adc_in      = (int'(adc_x) < X_RES) && (int'(adc_y) < Y_RES);
    assign frame_start = adc_pop && (adc_x == 11'd0) && (adc_y == 11'd0);

    // ---------------- freeze FSM next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LIVE: begin
                if (freeze_req) state_next = FREEZE_ARMED;
            end
            FREEZE_ARMED: begin
                if (!freeze_req)      state_next = LIVE;
                else if (frame_start) state_next = FROZEN;
            end
            FROZEN: begin
                if (!freeze_req) state_next = THAW_ARMED;
            end
            THAW_ARMED: begin
                if (freeze_req)       state_next = FROZEN;
                else if (frame_start) state_next = LIVE;
            end
            default: state_next = LIVE;
        endcase
    end

    // Write ownership follows the post-transition state, so the frame-start
    // word that freezes is dropped and the one that thaws is written. Using
    // the same state for both writers keeps ADC and SPI writes exclusive.
    logic adc_owns, spi_owns;
    logic adc_wr, adc_drop, spi_ack, spi_wr;
    logic spi_pixel_read_reg;

    assign adc_owns = (state_next == LIVE) || (state_next == FREEZE_ARMED);
    assign spi_owns = (state_next == FROZEN) || (state_next == THAW_ARMED);

    assign adc_wr   = adc_pop & adc_in & adc_owns;
    assign adc_drop = adc_pop & ~adc_in;

    // The pixel is still held during the acknowledge cycle, so that cycle is
    // skipped to avoid taking the same pixel twice.
    assign spi_ack = spi_pixel_ready & spi_owns & ~request_active & ~spi_pixel_read_reg;
    assign spi_wr  = spi_ack & spi_in;

    // ---------------- command mux ----------------
    logic            cmd_valid_next, cmd_we_next;
    logic [AW-1:0]   cmd_addr_next;
    logic [16:0]     cmd_wdata_next;

    always_comb begin
        cmd_valid_next = 1'b0;
        cmd_we_next    = 1'b0;
        cmd_addr_next  = '0;
        cmd_wdata_next = '0;
        if (request_active) begin
            if (req_in) begin
                cmd_valid_next = 1'b1;
                cmd_addr_next  = pix_addr(request_x[PRECISION-1:0], request_y[PRECISION-1:0]);
            end
        end else if (adc_wr) begin
            cmd_valid_next = 1'b1;
            cmd_we_next    = 1'b1;
            cmd_addr_next  = pix_addr(PRECISION'(adc_x), PRECISION'(adc_y));
            cmd_wdata_next = {1'b0, adc_rgb};
        end else if (spi_wr) begin
            cmd_valid_next = 1'b1;
            cmd_we_next    = 1'b1;
            cmd_addr_next  = pix_addr(spi_pixel_x[PRECISION-1:0], spi_pixel_y[PRECISION-1:0]);
            cmd_wdata_next = {1'b0, spi_pixel_in};
        end
    end

    // ---------------- registers ----------------
    // Read tag pipeline: stage 0 is visible together with the command, stage
    // RD_LAT lines up with the matching sram_rdata.
    logic [RD_LAT:0] tag_valid_reg, tag_blank_reg;
    logic            cmd_valid_reg, cmd_we_reg, frozen_reg, request_ready_reg;
    logic [AW-1:0]   cmd_addr_reg;
    logic [16:0]     cmd_wdata_reg;
    logic [15:0]     request_data_reg, adc_drop_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= LIVE;
            frozen_reg         <= 1'b0;
            cmd_valid_reg      <= 1'b0;
            cmd_we_reg         <= 1'b0;
            cmd_addr_reg       <= '0;
            cmd_wdata_reg      <= '0;
            spi_pixel_read_reg <= 1'b0;
            adc_drop_count_reg <= '0;
            tag_valid_reg      <= '0;
            tag_blank_reg      <= '0;
            request_ready_reg  <= 1'b0;
            request_data_reg   <= '0;
        end else begin
            state_reg          <= state_next;
            frozen_reg         <= (state_next == FROZEN) || (state_next == THAW_ARMED);
            cmd_valid_reg      <= cmd_valid_next;
            cmd_we_reg         <= cmd_we_next;
            cmd_addr_reg       <= cmd_addr_next;
            cmd_wdata_reg      <= cmd_wdata_next;
            spi_pixel_read_reg <= spi_ack;

            if (adc_drop && (adc_drop_count_reg != 16'hFFFF))
                adc_drop_count_reg <= adc_drop_count_reg + 16'd1;

            tag_valid_reg <= {tag_valid_reg[RD_LAT-1:0], request_active};
            tag_blank_reg <= {tag_blank_reg[RD_LAT-1:0], request_active & ~req_in};

            request_ready_reg <= tag_valid_reg[RD_LAT];
            if (tag_valid_reg[RD_LAT])
                request_data_reg <= tag_blank_reg[RD_LAT] ? 16'h0000 : sram_rdata[15:0];
        end
    end

    // Bit 16 of the SRAM word carries no pixel data.
    logic unused_rdata_msb;
    assign unused_rdata_msb = sram_rdata[16];

    assign frozen         = frozen_reg;
    assign cmd_valid      = cmd_valid_reg;
    assign cmd_we         = cmd_we_reg;
    assign cmd_addr       = cmd_addr_reg;
    assign cmd_wdata      = cmd_wdata_reg;
    assign spi_pixel_read = spi_pixel_read_reg;
    assign adc_drop_count = adc_drop_count_reg;
    assign request_ready  = request_ready_reg;
    assign request_data   = request_data_reg;

endmodule

// File: tb/tb_sram_scheduler.sv
module tb_sram_scheduler;

    localparam int X_RES     = 800;
    localparam int Y_RES     = 600;
    localparam int PRECISION = 11;
    localparam int RD_LAT    = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 freeze_req = 1'b0;
    logic                 frozen;
    logic                 request_active = 1'b0;
    logic [PRECISION:0]   request_x = '0;
    logic [PRECISION:0]   request_y = '0;
    logic [15:0]          request_data;
    logic                 request_ready;
    logic [37:0]          adc_pixel_data = '0;
    logic                 adc_pixel_ready = 1'b0;
    logic                 adc_pixel_read;
    logic                 spi_pixel_ready = 1'b0;
    logic [15:0]          spi_pixel_in = '0;
    logic [PRECISION:0]   spi_pixel_x = '0;
    logic [PRECISION:0]   spi_pixel_y = '0;
    logic                 spi_pixel_read;
    logic                 cmd_valid;
    logic                 cmd_we;
    logic [19:0]          cmd_addr;
    logic [16:0]          cmd_wdata;
    logic [16:0]          sram_rdata = '0;
    logic [15:0]          adc_drop_count;

    always #5 clk = ~clk;

    sram_scheduler #(
        .X_RES(X_RES), .Y_RES(Y_RES), .PRECISION(PRECISION), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .freeze_req(freeze_req), .frozen(frozen),
        .request_active(request_active), .request_x(request_x), .request_y(request_y),
        .request_data(request_data), .request_ready(request_ready),
        .adc_pixel_data(adc_pixel_data), .adc_pixel_ready(adc_pixel_ready),
        .adc_pixel_read(adc_pixel_read),
        .spi_pixel_ready(spi_pixel_ready), .spi_pixel_in(spi_pixel_in),
        .spi_pixel_x(spi_pixel_x), .spi_pixel_y(spi_pixel_y),
        .spi_pixel_read(spi_pixel_read),
        .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .sram_rdata(sram_rdata),
        .adc_drop_count(adc_drop_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int spi_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc_at;
        logic        we;
        logic [19:0] addr;
        logic [16:0] wdata;
    } cmd_t;
    typedef struct {
        int          cyc_at;
        logic [15:0] data;
    } rd_t;

    cmd_t exp_cmd[$];
    rd_t  exp_rd[$];
    cmd_t mon_c;
    rd_t  mon_r;

    task automatic exp_c(input int at, input logic we, input logic [19:0] addr, input logic [16:0] wdata);
        cmd_t c;
        c.cyc_at = at; c.we = we; c.addr = addr; c.wdata = wdata;
        exp_cmd.push_back(c);
    endtask

    task automatic exp_r(input int at, input logic [15:0] data);
        rd_t r;
        r.cyc_at = at; r.data = data;
        exp_rd.push_back(r);
    endtask

    // Monitor: pops one expected entry whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL cmd_unexpected: got we=%0b addr=%0d wdata=0x%0h at cycle %0d, required no command",
                             cmd_we, cmd_addr, cmd_wdata, cyc);
                end else begin
                    mon_c = exp_cmd.pop_front();
                    check("cmd_cycle", 64'(cyc), 64'(mon_c.cyc_at));
                    check("cmd_we", 64'(cmd_we), 64'(mon_c.we));
                    check("cmd_addr", 64'(cmd_addr), 64'(mon_c.addr));
                    check("cmd_wdata", 64'(cmd_wdata), 64'(mon_c.wdata));
                end
            end else begin
                check("cmd_idle_zero", 64'({cmd_we, cmd_addr, cmd_wdata}), 64'd0);
            end
            if (request_ready) begin
                if (exp_rd.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rd_unexpected: got request_ready data=0x%0h at cycle %0d, required none",
                             request_data, cyc);
                end else begin
                    mon_r = exp_rd.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(mon_r.cyc_at));
                    check("rd_data", 64'(request_data), 64'(mon_r.data));
                end
            end
            if (spi_pixel_read) spi_pulses++;
        end
    end

    // ---------------- SRAM responder (models sram_interface) ----------------
    logic [16:0] mem [int];
    logic [16:0] rd_line [RD_LAT+1];

    initial begin
        mem[1610] = 17'h1ABCD;
        for (int i = 0; i <= RD_LAT; i++) rd_line[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = RD_LAT; i > 0; i--) rd_line[i] = rd_line[i-1];
            rd_line[0] = 17'h0;
            if (cmd_valid && !cmd_we && mem.exists(int'(cmd_addr)))
                rd_line[0] = mem[int'(cmd_addr)];
            if (cmd_valid && cmd_we)
                mem[int'(cmd_addr)] = cmd_wdata;
            sram_rdata = rd_line[RD_LAT];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic logic [37:0] adc_word(input int x, input int y, input logic [15:0] rgb);
        return {11'(x), 11'(y), rgb};
    endfunction

    // Well-behaved SPI requester: holds the pixel until the acknowledge is
    // seen, giving up after a 6-cycle window.
    task automatic spi_send(input int x, input int y, input logic [15:0] pix, output bit got);
        spi_pixel_ready = 1'b1;
        spi_pixel_x     = 12'(x);
        spi_pixel_y     = 12'(y);
        spi_pixel_in    = pix;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (spi_pixel_read) got = 1'b1;
            step();
            if (got) break;
        end
        spi_pixel_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit got;
        int base;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_request_ready", 64'(request_ready), 64'd0);
        check("rst_request_data", 64'(request_data), 64'd0);
        check("rst_drop_count", 64'(adc_drop_count), 64'd0);
        check("rst_frozen", 64'(frozen), 64'd0);
        check("rst_spi_read", 64'(spi_pixel_read), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Read (10,2) -> addr 1610, data 0xABCD after 5 cycles
        request_active = 1'b1; request_x = 12'd10; request_y = 12'd2;
        exp_c(cyc + 1, 1'b0, 20'd1610, 17'h0);
        exp_r(cyc + 5, 16'hABCD);
        step();
        request_active = 1'b0;
        idle(6);

        // Blank reads (-1,5) then (800,0), back to back
        request_active = 1'b1; request_x = 12'(-1); request_y = 12'd5;
        exp_r(cyc + 5, 16'h0000);
        step();
        request_x = 12'd800; request_y = 12'd0;
        exp_r(cyc + 5, 16'h0000);
        step();
        request_active = 1'b0;
        idle(6);
        check("drop_after_blank_reads", 64'(adc_drop_count), 64'd0);

        // LIVE ADC write at the far corner
        adc_pixel_ready = 1'b1; adc_pixel_data = adc_word(799, 599, 16'h1234);
        exp_c(cyc + 1, 1'b1, 20'd479999, 17'h01234);
        @(negedge clk);
        check("adc_read_live", 64'(adc_pixel_read), 64'd1);
        step();
        adc_pixel_ready = 1'b0;
        step();

        // Read holds the slot: ADC stalls, written one cycle later
        request_active = 1'b1; request_x = 12'd10; request_y = 12'd2;
        exp_c(cyc + 1, 1'b0, 20'd1610, 17'h0);
        exp_r(cyc + 5, 16'hABCD);
        adc_pixel_ready = 1'b1; adc_pixel_data = adc_word(799, 599, 16'h5678);
        @(negedge clk);
        check("adc_read_stalled", 64'(adc_pixel_read), 64'd0);
        step();
        request_active = 1'b0;
        exp_c(cyc + 1, 1'b1, 20'd479999, 17'h05678);
        @(negedge clk);
        check("adc_read_after_stall", 64'(adc_pixel_read), 64'd1);
        step();
        adc_pixel_ready = 1'b0;

        // y = Y_RES is out of bounds: consumed, counted, not written
        adc_pixel_ready = 1'b1; adc_pixel_data = adc_word(799, 600, 16'hFFFF);
        step();
        adc_pixel_ready = 1'b0;
        step();
        check("drop_live_oob", 64'(adc_drop_count), 64'd1);

        // Read back the stalled ADC write
        request_active = 1'b1; request_x = 12'd799; request_y = 12'd599;
        exp_c(cyc + 1, 1'b0, 20'd479999, 17'h0);
        exp_r(cyc + 5, 16'h5678);
        step();
        request_active = 1'b0;
        idle(6);

        // Freeze on frame start
        freeze_req = 1'b1;
        adc_pixel_ready = 1'b1; adc_pixel_data = adc_word(5, 0, 16'h0AAA);
        exp_c(cyc + 1, 1'b1, 20'd5, 17'h00AAA);
        step();
        adc_pixel_data = adc_word(0, 0, 16'h0BBB);
        @(negedge clk);
        check("frozen_while_armed", 64'(frozen), 64'd0);
        check("adc_read_frame_start", 64'(adc_pixel_read), 64'd1);
        step();
        adc_pixel_data = adc_word(3, 3, 16'h0CCC);
        @(negedge clk);
        check("frozen_after_frame_start", 64'(frozen), 64'd1);
        step();
        adc_pixel_data = adc_word(900, 1, 16'h0DDD);
        @(negedge clk);
        check("adc_read_frozen_discard", 64'(adc_pixel_read), 64'd1);
        step();
        adc_pixel_ready = 1'b0;
        @(negedge clk);
        check("drop_frozen_oob", 64'(adc_drop_count), 64'd2);
        step();

        // SPI (1,1)=0xF800 with a concurrent ADC discard, 6-cycle window
        base = spi_pulses;
        adc_pixel_ready = 1'b1; adc_pixel_data = adc_word(4, 4, 16'h0EEE);
        spi_pixel_ready = 1'b1; spi_pixel_x = 12'd1; spi_pixel_y = 12'd1; spi_pixel_in = 16'hF800;
        exp_c(cyc + 1, 1'b1, 20'd801, 17'h0F800);
        @(negedge clk);
        check("adc_read_with_spi", 64'(adc_pixel_read), 64'd1);
        step();
        adc_pixel_ready = 1'b0;
        @(negedge clk);
        check("spi_ack_pulse", 64'(spi_pixel_read), 64'd1);
        step();
        spi_pixel_ready = 1'b0;
        idle(4);
        check("spi_one_pulse", 64'(spi_pulses - base), 64'd1);

        // SPI waits for a read to release the slot
        request_active = 1'b1; request_x = 12'd1; request_y = 12'd1;
        exp_c(cyc + 1, 1'b0, 20'd801, 17'h0);
        exp_r(cyc + 5, 16'hF800);
        spi_pixel_ready = 1'b1; spi_pixel_x = 12'd2; spi_pixel_y = 12'd1; spi_pixel_in = 16'h07E0;
        exp_c(cyc + 2, 1'b1, 20'd802, 17'h007E0);
        step();
        request_active = 1'b0;
        step();
        @(negedge clk);
        check("spi_ack_after_read", 64'(spi_pixel_read), 64'd1);
        step();
        spi_pixel_ready = 1'b0;
        idle(6);

        // Out-of-bounds SPI pixel: acknowledged, no write
        base = spi_pulses;
        spi_send(-3, 4, 16'h1234, got);
        check("spi_oob_ack", 64'(got), 64'd1);
        idle(2);
        check("spi_oob_pulses", 64'(spi_pulses - base), 64'd1);

        // Thaw: THAW_ARMED still accepts SPI
        freeze_req = 1'b0;
        step();
        @(negedge clk);
        check("frozen_thaw_armed", 64'(frozen), 64'd1);
        step();
        exp_c(cyc + 1, 1'b1, 20'd2, 17'h0001F);
        spi_send(2, 0, 16'h001F, got);
        check("spi_ack_thaw_armed", 64'(got), 64'd1);

        // Frame start in THAW_ARMED is written and returns to LIVE
        adc_pixel_ready = 1'b1; adc_pixel_data = adc_word(0, 0, 16'h0CCC);
        exp_c(cyc + 1, 1'b1, 20'd0, 17'h00CCC);
        step();
        adc_pixel_ready = 1'b0;
        @(negedge clk);
        check("frozen_after_thaw", 64'(frozen), 64'd0);
        step();
        spi_send(3, 0, 16'h1111, got);
        check("spi_ignored_live", 64'(got), 64'd0);

        // Async reset while a read command is on the bus
        check("drop_before_reset", 64'(adc_drop_count), 64'd2);
        request_active = 1'b1; request_x = 12'd5; request_y = 12'd0;
        step();
        request_active = 1'b0;
        check("cmd_valid_before_reset", 64'(cmd_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_cmd_valid", 64'(cmd_valid), 64'd0);
        check("areset_cmd_bus", 64'({cmd_we, cmd_addr, cmd_wdata}), 64'd0);
        check("areset_request_ready", 64'(request_ready), 64'd0);
        check("areset_request_data", 64'(request_data), 64'd0);
        check("areset_drop_count", 64'(adc_drop_count), 64'd0);
        check("areset_frozen", 64'(frozen), 64'd0);
        check("areset_spi_read", 64'(spi_pixel_read), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        idle(8);

        // Back in LIVE after reset: ADC writes again
        adc_pixel_ready = 1'b1; adc_pixel_data = adc_word(4, 4, 16'h4444);
        exp_c(cyc + 1, 1'b1, 20'd3204, 17'h04444);
        step();
        adc_pixel_ready = 1'b0;
        idle(4);

        check("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
